// File: rtl/pipe_dma_pkg.sv
// Shared definitions for the pipelined-bus DMA master.
// FSM state encodings, word size, default IO window base and the alignment helper.
// No logic of its own; imported by pipe_dma_master.
package pipe_dma_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Byte stride between consecutive 32-bit words
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // Start of the memory-mapped hex/led window
  localparam logic [31:0] IO_BASE_DEFAULT = 32'hffffff00;

  // A byte address is usable for a word access only when its low two bits are zero
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pipe_dma_master.sv
// pipe_dma_master: copies len 32-bit words src->dst over the data-memory bus (read cycle, write cycle per word).
// Latency: 2*len+1 cycles from accepted start to the done pulse; 1 cycle for len==0 or misaligned addresses.
// No backpressure: bus is assumed granted while busy; start outside IDLE is ignored.
// Optional macro DMA_FIXED_DST_EN adds input dst_fixed that holds the destination address constant.
module pipe_dma_master
  import pipe_dma_pkg::*;
#(
  parameter int          LEN_W   = 8,
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
`ifdef DMA_FIXED_DST_EN
  input  logic             dst_fixed,
`endif
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             io_hit,
  output logic [LEN_W-1:0] remaining,
  output logic [31:0]      bus_addr,
  output logic [31:0]      bus_wdata,
  output logic             bus_we,
  input  logic [31:0]      bus_rdata
);

  logic [1:0]  state;
  logic [31:0] src_q;
  logic [31:0] dst_q;
  logic [31:0] data_q;
  logic        fixed_q;

`ifdef DMA_FIXED_DST_EN
  logic fixed_in;
  assign fixed_in = dst_fixed;
`else
  logic fixed_in;
  assign fixed_in = 1'b0;
`endif

  // Sequencer: accept a request in IDLE, then alternate read/write until the count runs out
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      data_q    <= '0;
      fixed_q   <= 1'b0;
      remaining <= '0;
      error     <= 1'b0;
      io_hit    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            src_q   <= src_addr;
            dst_q   <= dst_addr;
            fixed_q <= fixed_in;
            error   <= 1'b0;
            io_hit  <= 1'b0;
            if (!is_word_aligned(src_addr) || !is_word_aligned(dst_addr)) begin
              // Misaligned request is rejected without touching the bus
              error     <= 1'b1;
              remaining <= '0;
              state     <= ST_DONE;
            end else if (len == '0) begin
              remaining <= '0;
              state     <= ST_DONE;
            end else begin
              remaining <= len;
              state     <= ST_READ;
            end
          end
        end
        ST_READ: begin
          data_q <= bus_rdata;
          state  <= ST_WRITE;
        end
        ST_WRITE: begin
          // Address arithmetic wraps modulo 2^32 with no special handling
          src_q <= src_q + WORD_BYTES;
          if (!fixed_q) begin
            dst_q <= dst_q + WORD_BYTES;
          end
          remaining <= remaining - LEN_W'(1);
          if (dst_q[31:8] == IO_BASE[31:8]) begin
            io_hit <= 1'b1;
          end
          state <= (remaining == LEN_W'(1)) ? ST_DONE : ST_READ;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus drive and status decode; a write in flight is squashed the moment reset rises
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_we    = 1'b0;
    case (state)
      ST_READ: begin
        busy     = 1'b1;
        bus_addr = src_q;
      end
      ST_WRITE: begin
        busy      = 1'b1;
        bus_addr  = dst_q;
        bus_wdata = data_q;
        bus_we    = !reset;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pipe_dma_master.sv
// Directed bench for pipe_dma_master with a 256-word memory model on the bus.
// Memory index is bus_addr[9:2], so 0xffffff00 lands on word 192 and 0xfffffffc on word 255.
// Build with DMA_FIXED_DST_EN defined to exercise the fixed-destination streaming case.
module tb_pipe_dma_master;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [7:0]  len;
`ifdef DMA_FIXED_DST_EN
  logic        dst_fixed;
`endif
  logic        busy;
  logic        done;
  logic        error;
  logic        io_hit;
  logic [7:0]  remaining;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic [31:0] bus_rdata;

  int checks;
  int errors;

  logic [31:0] mem [0:255];
  int          wr_count;
  int          rd_count;
  logic [31:0] rd_log [0:63];

  pipe_dma_master dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
`ifdef DMA_FIXED_DST_EN
    .dst_fixed (dst_fixed),
`endif
    .busy      (busy),
    .done      (done),
    .error     (error),
    .io_hit    (io_hit),
    .remaining (remaining),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_rdata (bus_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Combinational read port, as the data memory presents it
  assign bus_rdata = mem[bus_addr[9:2]];

  // Memory write port plus logs of writes and read addresses
  always @(posedge clock) begin
    if (bus_we) begin
      mem[bus_addr[9:2]] <= bus_wdata;
      wr_count <= wr_count + 1;
    end else if (busy && rd_count < 64) begin
      rd_log[rd_count] <= bus_addr;
      rd_count <= rd_count + 1;
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    checks++;
    if ({busy, done, error, io_hit, bus_we} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags actual=%b required=00000", {busy, done, error, io_hit, bus_we});
    end
    checks++;
    if (bus_addr !== 32'h0 || bus_wdata !== 32'h0 || remaining !== 8'h0) begin
      errors++;
      $display("FAIL reset_bus actual addr=%h wdata=%h rem=%h required=0", bus_addr, bus_wdata, remaining);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_during_reset actual busy=%b required=0", busy);
    end
  endtask

  task automatic test_copy();
    int w0, we_cyc, done_n, done_k;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    for (int i = 16; i < 20; i++) mem[i] = 32'h0;
    w0 = wr_count; we_cyc = 0; done_n = 0; done_k = 0;
    src_addr = 32'h0; dst_addr = 32'h40; len = 8'd4; start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (k == 1) begin
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || remaining !== 8'd4 || bus_addr !== 32'h0 || bus_we !== 1'b0) begin
          errors++;
          $display("FAIL copy_first_read actual busy=%b rem=%0d addr=%h we=%b required 1 4 0 0", busy, remaining, bus_addr, bus_we);
        end
      end
      if (k == 2) begin
        checks++;
        if (bus_we !== 1'b1 || bus_addr !== 32'h40 || bus_wdata !== 32'h11) begin
          errors++;
          $display("FAIL copy_first_write actual we=%b addr=%h wdata=%h required 1 40 11", bus_we, bus_addr, bus_wdata);
        end
      end
      if (bus_we) we_cyc++;
      if (done) begin done_n++; done_k = k; end
    end
    checks++;
    if (done_n != 1 || done_k != 9) begin
      errors++;
      $display("FAIL copy_done actual pulses=%0d at=%0d required 1 at 9", done_n, done_k);
    end
    checks++;
    if (we_cyc != 4 || wr_count - w0 != 4) begin
      errors++;
      $display("FAIL copy_we_cycles actual=%0d writes=%0d required=4", we_cyc, wr_count - w0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16 + i] !== 32'h11 * (i + 1)) begin
        errors++;
        $display("FAIL copy_data[%0d] actual=%h required=%h", i, mem[16 + i], 32'h11 * (i + 1));
      end
    end
    checks++;
    if (error !== 1'b0 || io_hit !== 1'b0 || remaining !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL copy_status actual err=%b io=%b rem=%0d busy=%b required 0 0 0 0", error, io_hit, remaining, busy);
    end
  endtask

  task automatic test_len_zero();
    int w0, done_n;
    w0 = wr_count; done_n = 0;
    src_addr = 32'h0; dst_addr = 32'h40; len = 8'd0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0 || bus_we !== 1'b0) begin
      errors++;
      $display("FAIL len0_done actual done=%b busy=%b err=%b we=%b required 1 0 0 0", done, busy, error, bus_we);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (done) done_n++;
    end
    checks++;
    if (wr_count != w0 || done_n != 0) begin
      errors++;
      $display("FAIL len0_quiet actual writes=%0d extra_done=%0d required 0 0", wr_count - w0, done_n);
    end
  endtask

  task automatic test_misaligned();
    int w0, done_k;
    w0 = wr_count;
    src_addr = 32'h2; dst_addr = 32'h40; len = 8'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || error !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL misalign_done actual done=%b err=%b busy=%b required 1 1 0", done, error, busy);
    end
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (error !== 1'b1 || wr_count != w0) begin
      errors++;
      $display("FAIL misalign_sticky actual err=%b writes=%0d required 1 0", error, wr_count - w0);
    end
    mem[32] = 32'h0;
    src_addr = 32'h0; dst_addr = 32'h80; len = 8'd1; start = 1'b1;
    done_k = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (k == 1) begin
        start = 1'b0;
        checks++;
        if (error !== 1'b0) begin
          errors++;
          $display("FAIL misalign_clear actual err=%b required 0", error);
        end
      end
      if (done) done_k = k;
    end
    checks++;
    if (done_k != 3 || mem[32] !== 32'h11) begin
      errors++;
      $display("FAIL misalign_followup actual done_at=%0d data=%h required 3 00000011", done_k, mem[32]);
    end
  endtask

  task automatic test_io_hit();
    mem[193] = 32'h0;
    src_addr = 32'h4; dst_addr = 32'hffffff04; len = 8'd1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clock);
    checks++;
    if (io_hit !== 1'b1 || mem[193] !== 32'h22) begin
      errors++;
      $display("FAIL io_hit actual io=%b data=%h required 1 00000022", io_hit, mem[193]);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    for (int i = 64; i < 68; i++) mem[i] = 32'h0;
    w0 = wr_count;
    src_addr = 32'h0; dst_addr = 32'h100; len = 8'd4; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    // Second WRITE cycle
    checks++;
    if (bus_we !== 1'b1 || bus_addr !== 32'h104) begin
      errors++;
      $display("FAIL rstmid_in_write actual we=%b addr=%h required 1 00000104", bus_we, bus_addr);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || bus_we !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_abort actual busy=%b we=%b required 0 0", busy, bus_we);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (wr_count - w0 != 1 || mem[64] !== 32'h11 || mem[65] !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_writes actual n=%0d w0=%h w1=%h required 1 00000011 00000000", wr_count - w0, mem[64], mem[65]);
    end
  endtask

  task automatic test_back_to_back();
    int w0, r0, done_n, done_k;
    mem[255] = 32'haaaa0001; mem[0] = 32'h11;
    mem[128] = 32'h0; mem[129] = 32'h0;
    w0 = wr_count; r0 = rd_count; done_n = 0; done_k = 0;
    src_addr = 32'hfffffffc; dst_addr = 32'h200; len = 8'd2; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 5) start = 1'b0;
      if (done) begin done_n++; done_k = k; end
    end
    checks++;
    if (done_n != 1 || done_k != 5) begin
      errors++;
      $display("FAIL b2b_done actual pulses=%0d at=%0d required 1 at 5", done_n, done_k);
    end
    checks++;
    if (wr_count - w0 != 2 || rd_count - r0 != 2) begin
      errors++;
      $display("FAIL b2b_count actual writes=%0d reads=%0d required 2 2", wr_count - w0, rd_count - r0);
    end
    checks++;
    if (rd_log[r0] !== 32'hfffffffc || rd_log[r0 + 1] !== 32'h0) begin
      errors++;
      $display("FAIL b2b_wrap actual %h %h required fffffffc 00000000", rd_log[r0], rd_log[r0 + 1]);
    end
    checks++;
    if (mem[128] !== 32'haaaa0001 || mem[129] !== 32'h11) begin
      errors++;
      $display("FAIL b2b_data actual %h %h required aaaa0001 00000011", mem[128], mem[129]);
    end
  endtask

`ifdef DMA_FIXED_DST_EN
  task automatic test_fixed_dst();
    int w0;
    mem[8] = 32'h40; mem[9] = 32'h79; mem[192] = 32'h0; mem[193] = 32'h0;
    w0 = wr_count;
    src_addr = 32'h20; dst_addr = 32'hffffff00; len = 8'd2; dst_fixed = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    dst_fixed = 1'b0;
    for (int k = 0; k < 6; k++) @(negedge clock);
    checks++;
    if (mem[192] !== 32'h79 || mem[193] !== 32'h0 || wr_count - w0 != 2) begin
      errors++;
      $display("FAIL fixed_dst actual hex0=%h next=%h writes=%0d required 00000079 00000000 2", mem[192], mem[193], wr_count - w0);
    end
    checks++;
    if (io_hit !== 1'b1) begin
      errors++;
      $display("FAIL fixed_io_hit actual=%b required=1", io_hit);
    end
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    wr_count = 0; rd_count = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    reset = 1'b1; start = 1'b0;
    src_addr = 32'h0; dst_addr = 32'h0; len = 8'd0;
`ifdef DMA_FIXED_DST_EN
    dst_fixed = 1'b0;
`endif
    @(negedge clock);
    test_reset();
    test_copy();
    test_len_zero();
    test_misaligned();
    test_io_hit();
    test_reset_mid();
    test_back_to_back();
`ifdef DMA_FIXED_DST_EN
    test_fixed_dst();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
